// File: rtl/hdmi_init_sequencer.sv
// rtl/hdmi_init_sequencer.sv - table-driven HDMI init sequencer feeding the I2C register-transaction block
// Walks a ROM of (op, chip, reg, value) entries, then polls HPD and reruns the table on HPD rising or restart.
module hdmi_init_sequencer #(
  parameter int         ADDR_W      = 6,
  parameter int         DELAY_UNIT  = 27000,
  parameter int         POLL_CYCLES = 270000,
  parameter logic [6:0] HPD_CHIP    = 7'h39,
  parameter logic [7:0] HPD_REG     = 8'h42,
  parameter int         HPD_BIT     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [24:0]       tbl_data,
  output logic [6:0]        chip_addr,
  output logic [7:0]        reg_addr,
  output logic [7:0]        value,
  output logic              is_read,
  output logic              enable,
  input  logic [7:0]        data,
  input  logic              done,
  output logic              ready,
  output logic              busy
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_ISSUE   = 4'd2;
  localparam logic [3:0] S_ACK     = 4'd3;
  localparam logic [3:0] S_CPLT    = 4'd4;
  localparam logic [3:0] S_DELAY   = 4'd5;
  localparam logic [3:0] S_PWAIT   = 4'd6;
  localparam logic [3:0] S_MONITOR = 4'd7;
  localparam logic [3:0] S_MWAIT   = 4'd8;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_DELAY   = 2'd1;
  localparam logic [1:0] OP_WAITBIT = 2'd2;

  localparam logic [23:0] POLL_LOAD = 24'(POLL_CYCLES);
  localparam logic [23:0] UNIT      = 24'(DELAY_UNIT);

  logic [3:0]  state;
  logic [23:0] count;
  logic        monitor;
  logic        hpd_prev;
  logic        hpd_seen;
  logic        restart_pend;
  logic        pend;
  logic        bit_match;
  logic        hpd_now;
  logic        last_entry;

  assign pend       = restart_pend | restart;
  assign bit_match  = (data[value[2:0]] == value[3]);
  assign hpd_now    = data[HPD_BIT];
  assign last_entry = &tbl_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_FETCH;
      tbl_addr     <= '0;
      chip_addr    <= 7'd0;
      reg_addr     <= 8'd0;
      value        <= 8'd0;
      is_read      <= 1'b0;
      enable       <= 1'b0;
      ready        <= 1'b0;
      busy         <= 1'b0;
      count        <= 24'd0;
      monitor      <= 1'b0;
      hpd_prev     <= 1'b0;
      hpd_seen     <= 1'b0;
      restart_pend <= 1'b0;
    end else begin
      enable <= 1'b0;
      if (restart) restart_pend <= 1'b1;
      // A restart never cuts a transaction short; ACK/CPLT honour it on completion.
      if (pend && state != S_ACK && state != S_CPLT) begin
        state        <= S_FETCH;
        tbl_addr     <= '0;
        ready        <= 1'b0;
        busy         <= 1'b1;
        monitor      <= 1'b0;
        restart_pend <= 1'b0;
      end else begin
        case (state)
          S_FETCH: begin
            busy  <= 1'b1;
            state <= S_DECODE;
          end
          S_DECODE: begin
            chip_addr <= tbl_data[22:16];
            reg_addr  <= tbl_data[15:8];
            value     <= tbl_data[7:0];
            is_read   <= (tbl_data[24:23] == OP_WAITBIT);
            case (tbl_data[24:23])
              OP_WRITE, OP_WAITBIT: state <= S_ISSUE;
              OP_DELAY: begin
                count <= 24'(tbl_data[7:0]) * UNIT;
                state <= S_DELAY;
              end
              default: begin
                busy    <= 1'b0;
                ready   <= 1'b0;
                monitor <= 1'b1;
                state   <= S_MONITOR;
              end
            endcase
          end
          S_ISSUE: begin
            if (done) begin
              enable <= 1'b1;
              state  <= S_ACK;
            end
          end
          S_ACK: begin
            if (!done) state <= S_CPLT;
          end
          S_CPLT: begin
            if (done) begin
              if (monitor) begin
                hpd_prev <= hpd_now;
                hpd_seen <= 1'b1;
              end
              if (pend) begin
                state        <= S_FETCH;
                tbl_addr     <= '0;
                ready        <= 1'b0;
                busy         <= 1'b1;
                monitor      <= 1'b0;
                restart_pend <= 1'b0;
              end else if (monitor) begin
                // The very first HPD sample only establishes the baseline.
                if (hpd_seen && !hpd_prev && hpd_now) begin
                  state    <= S_FETCH;
                  tbl_addr <= '0;
                  ready    <= 1'b0;
                  busy     <= 1'b1;
                  monitor  <= 1'b0;
                end else begin
                  ready <= hpd_now;
                  count <= POLL_LOAD;
                  state <= S_MWAIT;
                end
              end else if (is_read && !bit_match) begin
                count <= POLL_LOAD;
                state <= S_PWAIT;
              end else begin
                tbl_addr <= tbl_addr + ADDR_W'(1);
                if (last_entry) begin
                  busy    <= 1'b0;
                  ready   <= 1'b0;
                  monitor <= 1'b1;
                  state   <= S_MONITOR;
                end else begin
                  state <= S_FETCH;
                end
              end
            end
          end
          S_DELAY: begin
            if (count <= 24'd1) begin
              tbl_addr <= tbl_addr + ADDR_W'(1);
              if (last_entry) begin
                busy    <= 1'b0;
                ready   <= 1'b0;
                monitor <= 1'b1;
                state   <= S_MONITOR;
              end else begin
                state <= S_FETCH;
              end
            end else begin
              count <= count - 24'd1;
            end
          end
          S_PWAIT: begin
            if (count == 24'd0) state <= S_ISSUE;
            else count <= count - 24'd1;
          end
          S_MONITOR: begin
            chip_addr <= HPD_CHIP;
            reg_addr  <= HPD_REG;
            value     <= 8'd0;
            is_read   <= 1'b1;
            state     <= S_ISSUE;
          end
          S_MWAIT: begin
            if (count == 24'd0) state <= S_MONITOR;
            else count <= count - 24'd1;
          end
          default: state <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdmi_init_sequencer.sv
// tb/tb_hdmi_init_sequencer.sv - directed self-checking bench for hdmi_init_sequencer
// Registered ROM plus a transaction-block model that holds done low for 20 cycles per request.
module tb_hdmi_init_sequencer;

  localparam int ADDR_W      = 6;
  localparam int DELAY_UNIT  = 10;
  localparam int POLL_CYCLES = 50;
  localparam int LIMIT       = 3000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              restart = 1'b0;
  logic [ADDR_W-1:0] tbl_addr;
  logic [24:0]       tbl_data;
  logic [6:0]        chip_addr;
  logic [7:0]        reg_addr;
  logic [7:0]        value;
  logic              is_read;
  logic              enable;
  logic [7:0]        data;
  logic              done;
  logic              ready;
  logic              busy;

  hdmi_init_sequencer #(
    .ADDR_W(ADDR_W), .DELAY_UNIT(DELAY_UNIT), .POLL_CYCLES(POLL_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .chip_addr(chip_addr), .reg_addr(reg_addr), .value(value),
    .is_read(is_read), .enable(enable), .data(data), .done(done),
    .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  chip;
    logic [7:0]  rg;
    logic [7:0]  val;
    logic        rd;
    logic [31:0] cyc;
  } txn_t;

  txn_t        log_q[$];
  int          addr_cyc[$];
  logic [24:0] rom [0:63];
  logic [7:0]  resp [0:3];
  int          resp_n;
  int          resp_idx;
  logic [7:0]  rd_default;
  int          cyc;
  int          busy_cnt;
  int          bad_enable;
  int          checks;
  int          failures;
  int          lbase;
  int          abase;
  logic [ADDR_W-1:0] last_addr;

  always @(posedge clk) tbl_data <= rom[tbl_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      done     <= 1'b1;
      busy_cnt <= 0;
      data     <= 8'h00;
      resp_idx <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) done <= 1'b1;
      if (enable) bad_enable <= bad_enable + 1;
    end else if (enable) begin
      if (!done) bad_enable <= bad_enable + 1;
      log_q.push_back({chip_addr, reg_addr, value, is_read, 32'(cyc)});
      if (is_read && resp_idx < resp_n) begin
        data     <= resp[resp_idx];
        resp_idx <= resp_idx + 1;
      end else if (is_read) begin
        data <= rd_default;
      end else begin
        data <= 8'h00;
      end
      done     <= 1'b0;
      busy_cnt <= 20;
    end
  end

  always @(negedge clk) begin
    if (tbl_addr != last_addr) addr_cyc.push_back(cyc);
    last_addr = tbl_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] ent(input logic [1:0] op, input logic [6:0] c,
                                      input logic [7:0] r, input logic [7:0] v);
    return {op, c, r, v};
  endfunction

  function automatic logic [31:0] fld(input int idx);
    txn_t t;
    t = log_q[idx];
    return 32'({t.chip, t.rg, t.val, t.rd});
  endfunction

  function automatic logic [31:0] txn(input logic [6:0] c, input logic [7:0] r,
                                      input logic [7:0] v, input logic rd);
    return 32'({c, r, v, rd});
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return busy;
      1:       return ready;
      default: return enable;
    endcase
  endfunction

  task automatic wait_until(input int sel, input logic lvl, input string tag);
    int n = 0;
    while (sig(sel) !== lvl && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < LIMIT), 32'd1);
  endtask

  task automatic wait_log(input int idx, input string tag);
    int n = 0;
    while (log_q.size() <= idx && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < LIMIT), 32'd1);
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    restart = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) rom[i] = ent(2'b11, 7'h00, 8'h00, 8'h00);
    resp_n = 0;
  endtask

  task automatic release_reset(input logic [7:0] dflt);
    rd_default = dflt;
    lbase = log_q.size();
    reset = 1'b1;
    @(negedge clk);
    abase = addr_cyc.size();
  endtask

  task automatic check_reset_outputs(input string pre);
    check({pre, "_tbl_addr"}, 32'(tbl_addr), 32'd0);
    check({pre, "_chip_addr"}, 32'(chip_addr), 32'd0);
    check({pre, "_reg_addr"}, 32'(reg_addr), 32'd0);
    check({pre, "_value"}, 32'(value), 32'd0);
    check({pre, "_is_read"}, 32'(is_read), 32'd0);
    check({pre, "_enable"}, 32'(enable), 32'd0);
    check({pre, "_ready"}, 32'(ready), 32'd0);
    check({pre, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int g1;
    int g2;
    checks = 0;
    failures = 0;
    rd_default = 8'h00;

    // Reset values.
    hold_reset();
    check_reset_outputs("rst");

    // Two writes then END.
    hold_reset();
    rom[0] = ent(2'b00, 7'h39, 8'h41, 8'h10);
    rom[1] = ent(2'b00, 7'h39, 8'h98, 8'h03);
    release_reset(8'h00);
    wait_until(0, 1'b0, "wr_busy_fall");
    check("wr_count", 32'(log_q.size() - lbase), 32'd2);
    check("wr_txn0", fld(lbase), txn(7'h39, 8'h41, 8'h10, 1'b0));
    check("wr_txn1", fld(lbase + 1), txn(7'h39, 8'h98, 8'h03, 1'b0));
    wait_log(lbase + 2, "wr_mon_to");
    check("wr_mon_read", fld(lbase + 2), txn(7'h39, 8'h42, 8'h00, 1'b1));
    check("wr_ready_low", 32'(ready), 32'd0);

    // DELAY 3 ticks, then DELAY 0.
    hold_reset();
    rom[0] = ent(2'b00, 7'h39, 8'h01, 8'h02);
    rom[1] = ent(2'b01, 7'h00, 8'h00, 8'h03);
    rom[2] = ent(2'b01, 7'h00, 8'h00, 8'h00);
    rom[3] = ent(2'b00, 7'h39, 8'h55, 8'h66);
    release_reset(8'h00);
    wait_until(0, 1'b0, "dly_busy_fall");
    g1 = addr_cyc[abase + 1] - addr_cyc[abase];
    g2 = addr_cyc[abase + 2] - addr_cyc[abase + 1];
    check("dly3_gap", 32'(g1 >= 29 && g1 <= 33), 32'd1);
    check("dly0_gap", 32'(g2 >= 2 && g2 <= 4), 32'd1);
    check("dly_after", fld(lbase + 1), txn(7'h39, 8'h55, 8'h66, 1'b0));

    // WAITBIT bit 6 == 1, reads 00, 00, 40.
    hold_reset();
    rom[0] = ent(2'b10, 7'h39, 8'h42, 8'h0E);
    rom[1] = ent(2'b00, 7'h39, 8'h11, 8'h22);
    resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h40; resp_n = 3;
    release_reset(8'h00);
    wait_until(0, 1'b0, "wb_busy_fall");
    check("wb_count", 32'(log_q.size() - lbase), 32'd4);
    check("wb_read0", fld(lbase), txn(7'h39, 8'h42, 8'h0E, 1'b1));
    check("wb_read2", fld(lbase + 2), txn(7'h39, 8'h42, 8'h0E, 1'b1));
    check("wb_gap01", 32'(log_q[lbase + 1].cyc - log_q[lbase].cyc >= 50), 32'd1);
    check("wb_gap12", 32'(log_q[lbase + 2].cyc - log_q[lbase + 1].cyc >= 50), 32'd1);
    check("wb_next", fld(lbase + 3), txn(7'h39, 8'h11, 8'h22, 1'b0));

    // Monitor: HPD reads 40, 00, 40.
    hold_reset();
    rom[0] = ent(2'b00, 7'h39, 8'h41, 8'h10);
    resp[0] = 8'h40; resp[1] = 8'h00; resp[2] = 8'h40; resp_n = 3;
    release_reset(8'h40);
    wait_until(0, 1'b0, "mon_busy_fall");
    wait_until(1, 1'b1, "mon_ready_hi");
    check("mon_no_restart", 32'(busy), 32'd0);
    wait_until(1, 1'b0, "mon_ready_lo");
    check("mon_lo_busy", 32'(busy), 32'd0);
    wait_until(0, 1'b1, "mon_rerun");
    check("mon_rerun_addr", 32'(tbl_addr), 32'd0);
    check("mon_rerun_ready", 32'(ready), 32'd0);
    n = log_q.size();
    wait_log(n, "mon_rerun_to");
    check("mon_rerun_txn", fld(n), txn(7'h39, 8'h41, 8'h10, 1'b0));
    wait_until(1, 1'b1, "mon_ready_again");

    // restart during S_ACK of entry 1.
    hold_reset();
    rom[0] = ent(2'b00, 7'h39, 8'h01, 8'hAA);
    rom[1] = ent(2'b00, 7'h39, 8'h02, 8'hBB);
    rom[2] = ent(2'b00, 7'h39, 8'h03, 8'hCC);
    release_reset(8'h00);
    n = 0;
    while (!(enable === 1'b1 && reg_addr == 8'h02) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("rs_ack_seen", 32'(n < LIMIT), 32'd1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_log(lbase + 2, "rs_next_to");
    check("rs_inflight", fld(lbase + 1), txn(7'h39, 8'h02, 8'hBB, 1'b0));
    check("rs_entry0", fld(lbase + 2), txn(7'h39, 8'h01, 8'hAA, 1'b0));

    // reset mid-transaction.
    hold_reset();
    rom[0] = ent(2'b00, 7'h39, 8'h41, 8'h10);
    rom[1] = ent(2'b00, 7'h39, 8'h98, 8'h03);
    release_reset(8'h00);
    wait_log(lbase, "mid_first_to");
    repeat (5) @(negedge clk);
    check("mid_inflight", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid");
    release_reset(8'h00);
    wait_log(lbase, "mid_again_to");
    check("mid_entry0", fld(lbase), txn(7'h39, 8'h41, 8'h10, 1'b0));

    // Table overrun: 64 writes, no END.
    hold_reset();
    for (int i = 0; i < 64; i++) rom[i] = ent(2'b00, 7'h39, 8'(i), 8'(i));
    release_reset(8'h00);
    wait_until(0, 1'b0, "ovr_busy_fall");
    check("ovr_count", 32'(log_q.size() - lbase), 32'd64);
    check("ovr_last", fld(lbase + 63), txn(7'h39, 8'h3F, 8'h3F, 1'b0));
    wait_log(lbase + 64, "ovr_mon_to");
    check("ovr_mon_read", fld(lbase + 64), txn(7'h39, 8'h42, 8'h00, 1'b1));

    check("enable_while_busy", 32'(bad_enable), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdmi_init_sequencer.md
Name: hdmi_init_sequencer

Overview:
- Table-driven sequencer directly upstream of the I2C register-transaction block.
- Walks an external configuration ROM of (opcode, chip, reg, value) entries and issues one register transaction per entry over the enable/done handshake.
- Supports delays and poll-until-bit entries; after the table ends it monitors HPD by periodic reads.
- Reruns the table on HPD rising or on a restart request; reports `ready` to the video/control logic.

Parameters:
- ADDR_W, 6, width of table address (max 64 entries).
- DELAY_UNIT, 27000, clk cycles per delay tick (1 ms at 27 MHz); DELAY_UNIT*255 must fit in 24 bits.
- POLL_CYCLES, 270000, clk cycles between poll/monitor reads (10 ms).
- HPD_CHIP, 7'h39, chip address for HPD status read.
- HPD_REG, 8'h42, register holding HPD status.
- HPD_BIT, 6, bit index of HPD within HPD_REG.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- restart  in  1  single-cycle request to rerun the table from entry 0
- tbl_addr  out  ADDR_W  ROM address
- tbl_data  in  25  {op[1:0], chip[6:0], reg[7:0], value[7:0]}; valid 1 cycle after tbl_addr changes
- chip_addr  out  7  to transaction block
- reg_addr  out  8  to transaction block
- value  out  8  to transaction block
- is_read  out  1  1 = read transaction
- enable  out  1  single-cycle transaction request
- data  in  8  read result, valid when done rises
- done  in  1  high when transaction block idle
- ready  out  1  table complete and HPD high
- busy  out  1  high while table is executing

Behaviour:
- Reset values: tbl_addr=0, chip_addr=0, reg_addr=0, value=0, is_read=0, enable=0, ready=0, busy=0; state=S_FETCH, so the table starts immediately after reset release.
- Opcodes:
  - 00 WRITE: write value to chip/reg.
  - 01 DELAY: wait value*DELAY_UNIT cycles. value=0 means no wait; advance next cycle.
  - 10 WAITBIT: read chip/reg until data[value[2:0]] == value[3].
  - 11 END.
- S_FETCH: drive tbl_addr; busy=1; go to S_DECODE next cycle.
- S_DECODE: latch tbl_data fields, then branch:
  - WRITE or WAITBIT → S_ISSUE.
  - DELAY → S_DELAY.
  - END → S_MONITOR; ready=0 until the first HPD read completes.
- S_ISSUE: wait for done=1; then assert enable for exactly 1 cycle with chip_addr/reg_addr/value/is_read stable; go to S_ACK.
- S_ACK: wait for done=0; go to S_CPLT.
- S_CPLT: wait for done=1; sample data on that cycle.
  - Table phase, WRITE: tbl_addr+1 → S_FETCH.
  - Table phase, WAITBIT matched: tbl_addr+1 → S_FETCH.
  - Table phase, WAITBIT not matched: S_PWAIT (POLL_CYCLES), then S_ISSUE with the same entry.
  - Monitor phase: go to S_MWAIT.
- Output hold: chip_addr, reg_addr, value and is_read hold from enable until done rises.
- S_DELAY: 24-bit down-counter loaded with value*DELAY_UNIT; advance when it reaches 0.
- Table overrun: if tbl_addr wraps from 2^ADDR_W-1 to 0 without END, treat as END.
- S_MONITOR:
  - Issue a read of HPD_CHIP/HPD_REG through the same S_ISSUE/S_ACK/S_CPLT path.
  - On completion, hpd = data[HPD_BIT]; ready = hpd.
  - If previous hpd was 0 and the new hpd is 1, restart the table: tbl_addr=0, ready=0, busy=1.
  - Otherwise wait POLL_CYCLES (S_MWAIT) and read again.
  - Previous hpd resets to 0, so the first monitor read with HPD=1 sets ready and does not restart.
- restart:
  - Latched into a pending flag.
  - If asserted while a transaction is in flight (S_ACK/S_CPLT), the current transaction finishes first; then tbl_addr=0, ready=0, go to S_FETCH.
  - In any other state, it takes effect on the next cycle.
  - restart coinciding with an HPD rising edge causes a single restart, not two.
- enable never asserts while done=0. The handshake has no timeout: the downstream block guarantees done returns.
- Reset mid-operation aborts immediately to the reset values. The downstream block shares the same reset.

Test Plan:
- Table {WRITE 39/41/10, WRITE 39/98/03, END}, transaction model with done low for 20 cycles → exactly two enable pulses with (39,41,10,rd=0) then (39,98,03); busy falls at END.
- DELAY with value=3, DELAY_UNIT=10 → next fetch occurs 30±2 cycles after decode; value=0 advances with no delay.
- WAITBIT value=8'h0E (bit 6 == 1) on reg 42, model returns 00, 00, 40, POLL_CYCLES=50 → three reads spaced ≥50 cycles, then advance.
- Monitor: HPD reads return 40, 00, 40 → ready 1, then 0, then the table restarts from tbl_addr=0 with ready=0.
- restart pulsed during S_ACK → in-flight transaction completes, and the next enable is for entry 0.
- reset low mid-transaction → all outputs at reset values next cycle; after release the table restarts at entry 0.
